branch_predictor: RTL

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/bp_pkg.sv | 20 ++
 rtl/bp_perf_counter.sv | 19 +
 rtl/branch_predictor.sv | 109 ++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: 2-bit counter states, predictor modes,
// and the saturating counter update.
package bp_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    localparam int MODE_BTB = 0;
    localparam int MODE_BHT = 1;

    function automatic logic [1:0] satUpdate(input logic [1:0] cnt, input logic taken);
        if (taken) begin
            return (cnt == ST) ? ST : cnt + 2'd1;
        end
        return (cnt == SNT) ? SNT : cnt - 2'd1;
    endfunction

endpackage

// File: rtl/bp_perf_counter.sv
// Saturating event counter with enable and synchronous active-low reset.
module bp_perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (en && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with optional 2-bit BHT, zero-latency lookup, EX-stage update,
// mispredict detection and saturating statistics.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int MODE    = MODE_BHT,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pc_f,
    output logic             pred_taken,
    output logic [31:0]      pred_target,
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic             upd_taken,
    input  logic [31:0]      upd_target,
    input  logic             upd_pred_taken,
    input  logic [31:0]      upd_pred_target,
    output logic             mispredict,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_mispredicts
);

    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX;

    if ((ENTRIES < 4) || (ENTRIES > 1024) || ((ENTRIES & (ENTRIES - 1)) != 0)) begin : gBadEntries
        $error("ENTRIES must be a power of 2 in 4..1024");
    end

    logic [ENTRIES-1:0] validTab;
    logic [TAG_W-1:0]   tagTab    [ENTRIES];
    logic [31:0]        targetTab [ENTRIES];
    logic [1:0]         cntTab    [ENTRIES];

    logic [IDX-1:0] fIdx;
    logic [IDX-1:0] uIdx;
    logic           fHit;
    logic           uHit;
    logic [31:0]    actualNext;
    logic [31:0]    predictedNext;
    logic           unusedPcBits;

    // Instructions are word aligned, so the low two PC bits never take part.
    assign unusedPcBits = ^{pc_f[1:0], upd_pc[1:0]};

    assign fIdx = pc_f[IDX+1:2];
    assign uIdx = upd_pc[IDX+1:2];
    assign fHit = validTab[fIdx] && (tagTab[fIdx] == pc_f[31:IDX+2]);
    assign uHit = validTab[uIdx] && (tagTab[uIdx] == upd_pc[31:IDX+2]);

    always_comb begin
        pred_taken  = 1'b0;
        pred_target = pc_f + 32'd4;
        if (fHit) begin
            pred_target = targetTab[fIdx];
            pred_taken  = (MODE == MODE_BTB) ? 1'b1 : cntTab[fIdx][1];
        end
    end

    assign actualNext    = upd_taken      ? upd_target      : upd_pc + 32'd4;
    assign predictedNext = upd_pred_taken ? upd_pred_target : upd_pc + 32'd4;
    assign mispredict    = upd_valid && (actualNext != predictedNext);
    assign redirect_pc   = actualNext;

    // Tags and targets are left unreset; validity alone gates their use.
    always_ff @(posedge clk) begin
        if (!rst) begin
            validTab <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                cntTab[i] <= WNT;
            end
        end else if (upd_valid) begin
            if (uHit) begin
                if (upd_taken) begin
                    targetTab[uIdx] <= upd_target;
                    cntTab[uIdx]    <= satUpdate(cntTab[uIdx], 1'b1);
                end else if (MODE == MODE_BTB) begin
                    validTab[uIdx] <= 1'b0;
                end else begin
                    cntTab[uIdx] <= satUpdate(cntTab[uIdx], 1'b0);
                end
            end else if (upd_taken) begin
                validTab[uIdx]  <= 1'b1;
                tagTab[uIdx]    <= upd_pc[31:IDX+2];
                targetTab[uIdx] <= upd_target;
                cntTab[uIdx]    <= WT;
            end
        end
    end

    bp_perf_counter #(.CNT_W(CNT_W)) uBranchCnt (
        .clk   (clk),
        .rst   (rst),
        .en    (upd_valid),
        .count (stat_branches)
    );

    bp_perf_counter #(.CNT_W(CNT_W)) uMispredCnt (
        .clk   (clk),
        .rst   (rst),
        .en    (mispredict),
        .count (stat_mispredicts)
    );

endmodule
